reg8_rr_write_arbiter: RTL and testbench
========================================

# reg8_rr_write_arbiter

Round-robin write arbiter and controller for a shared 8-bit register. Up to N_REQ requesters each present a data byte with a req/ack handshake. The block grants one requester at a time, sequences the load into its internal register (same behaviour as the team's 8-bit DFF register), and drives the register value on PO. A 3-state FSM guarantees one clean load per grant and fair rotation between requesters.

## Interface
- N_REQ, 4, number of requesters; legal values 2..8
- WIDTH, 8, register and data width
- IDW, $clog2(N_REQ), width of the owner index
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately)
- req  input  N_REQ  per-requester request level; held until ack or abort
- data_in  input  N_REQ*WIDTH  requester i data is data_in[i*WIDTH +: WIDTH]; must stay stable while req[i]=1
- clr  input  1  synchronous clear request for the register
- gnt  output  N_REQ  one-hot grant; high only in LOAD
- ack  output  N_REQ  one-hot one-cycle pulse; high only in ACK
- owner  output  IDW  index of the current or last grantee
- busy  output  1  1 when state is not IDLE
- PO  output  WIDTH  registered contents of the shared register

## Operation
- Reset values: PO=0, gnt=0, ack=0, owner=0, busy=0, internal pointer ptr=0, state=IDLE.
- FSM states: IDLE, LOAD and ACK.
- IDLE:
  - If clr=1, PO<=0 and the FSM stays in IDLE. clr has priority, so no grant is issued that cycle.
  - Otherwise, if |req, the winner is the first i with req[i]=1, searching ptr, ptr+1, … mod N_REQ.
  - On a win: gnt<=onehot(winner), owner<=winner, state<=LOAD.
  - If req=0, the FSM stays in IDLE.
- LOAD:
  - If req[owner]=1: PO<=data_in[owner], ack<=onehot(owner), gnt<=0, ptr<=(owner+1) mod N_REQ, state<=ACK.
  - If req[owner]=0 (abort): gnt<=0, state<=IDLE. PO, ptr and ack are unchanged.
- ACK: ack<=0, state<=IDLE. req is ignored in this state.
- The requester must drop req on the cycle after it sees ack. A req still high in the next IDLE cycle is treated as a new request.
- clr is ignored in LOAD and ACK. It is not latched.
- Other requests arriving during LOAD or ACK wait. No request is lost as long as its req is held.
- Pointer wrap: after owner=N_REQ-1, ptr returns to 0.

## Timing
- req[i] high before edge E1, in IDLE with no clr: gnt[i] and busy are high after E1.
- After E2: PO=data_in[i] and ack[i]=1 (1 cycle, in the same cycle PO first shows the new value).
- After E3: ack=0, busy=0.
- Earliest next grant: after E4. Maximum throughput is one load per 3 cycles.
- Worst-case wait with all N_REQ requesting continuously: (N_REQ-1)*3 cycles before the grant.
- Reset asserted mid-operation (any state): outputs return to their reset values immediately (asynchronous reset). A load in progress is discarded, and no ack is issued.
- Simultaneous events:
  - clr together with req in IDLE: the clear wins and the grant is deferred by 1 cycle.
  - Several req bits rising on the same edge: the round-robin order decides the winner.

## Test plan
- Reset and single write: rst=0 then release, req=0001, data0=8'h94 → gnt=0001 after E1, PO=8'h94 with ack=0001 after E2, busy=0 after E3.
- Round-robin fairness: req=1111 held, data_i=8'h10+i (i.e. 8'h10, 8'h11, 8'h12, 8'h13), requesters dropping req only after their ack → grant order 0,1,2,3. PO takes 8'h10, 8'h11, 8'h12, 8'h13 at 3-cycle spacing. Re-raising req[0] → next grant goes to 0 after 3 (wrap).
- Pointer fairness: after requester 2 has been served, req=0101 → requester 0 wins over 2 (search starts at 3, wraps to 0).
- Abort: req[1] granted, then req[1] dropped during LOAD → no ack, PO keeps its previous value, and the next req=0010 is granted to 1 again (ptr unchanged).
- clr priority: PO=8'hA5, clr=1 and req=0100 in the same IDLE cycle → PO=0 and no gnt that cycle; gnt=0100 one cycle later, PO=data2 after the following edge.
- Async reset mid-LOAD: rst=0 between edges while gnt=1000 → PO, gnt, ack and busy are 0 immediately without waiting for a clk edge, and after release the FSM is in IDLE with ptr=0.

Source files
------------

// File: rtl/reg8_rr_write_arbiter.sv
// Round-robin write arbiter for a shared register. Requesters present a byte
// with a req/ack handshake; one is granted at a time, its byte is loaded into
// the register on the following cycle and acknowledged with a one-cycle pulse.
module reg8_rr_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [IDW-1:0]         owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       PO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_nxt;
  logic [IDW-1:0]     owner_nxt;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     idx;
  logic               found;
  logic [N_REQ-1:0]   gnt_nxt;
  logic [N_REQ-1:0]   ack_nxt;
  logic [WIDTH-1:0]   po_nxt;

  // Pick the first active request starting at ptr and wrapping around.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and next-output decisions for the IDLE/LOAD/ACK sequence.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    gnt_nxt   = gnt;
    ack_nxt   = ack;
    po_nxt    = PO;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        ack_nxt = '0;
        if (clr) begin
          po_nxt = '0;
        end else if (found) begin
          gnt_nxt      = '0;
          gnt_nxt[win] = 1'b1;
          owner_nxt    = win;
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        gnt_nxt = '0;
        if (req[owner]) begin
          po_nxt         = data_in[int'(owner)*WIDTH +: WIDTH];
          ack_nxt        = '0;
          ack_nxt[owner] = 1'b1;
          if (owner == IDW'(N_REQ - 1)) begin
            ptr_nxt = '0;
          end else begin
            ptr_nxt = owner + 1'b1;
          end
          state_nxt = ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACK: begin
        ack_nxt   = '0;
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        ack_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer, handshake outputs and the shared register itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      gnt   <= '0;
      ack   <= '0;
      PO    <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      gnt   <= gnt_nxt;
      ack   <= ack_nxt;
      PO    <= po_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg8_rr_write_arbiter.sv
// Self-checking bench for reg8_rr_write_arbiter: a vector table for the
// round-robin walk, hand sequences for abort/clear/reset corner cases, and
// randomized requesters compared against a slot-based reference model.
module tb_reg8_rr_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] dataIn;
  logic           clr;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   po;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           clr;
    logic [N-1:0]   eGnt;
    logic [N-1:0]   eAck;
    logic [W-1:0]   ePo;
    logic           eBusy;
    logic [1:0]     eOwner;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a grant occupies slot 1 (granted) then slot 2 (acked).
  int             mSlot;
  int             mOwner;
  int             mPtr;
  logic [W-1:0]   mPo;
  logic [N-1:0]   mGnt;
  logic [N-1:0]   mAck;
  logic           mBusy;
  logic [N-1:0]   rReq;
  logic [N*W-1:0] rData;
  logic           rClr;

  reg8_rr_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data_in(dataIn),
    .clr    (clr),
    .gnt    (gnt),
    .ack    (ack),
    .owner  (owner),
    .busy   (busy),
    .PO     (po)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic c);
    req    = r;
    dataIn = d;
    clr    = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eGnt, input logic [N-1:0] eAck,
                             input logic [W-1:0] ePo, input logic eBusy, input logic [1:0] eOwner);
    total++;
    if (gnt !== eGnt || ack !== eAck || po !== ePo || busy !== eBusy || owner !== eOwner) begin
      bad++;
      $display("[TB] FAIL %s: got gnt=%b ack=%b PO=%h busy=%b owner=%0d, want gnt=%b ack=%b PO=%h busy=%b owner=%0d",
               name, gnt, ack, po, busy, owner, eGnt, eAck, ePo, eBusy, eOwner);
    end
  endtask

  task automatic resetPulse();
    applyStimulus('0, '0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic vec_t mkVec(input logic [N-1:0] r, input logic [N-1:0] g, input logic [N-1:0] a,
                                 input logic [W-1:0] p, input logic b, input logic [1:0] o);
    vec_t v;
    v.req    = r;
    v.data   = 32'h13121110;
    v.clr    = 1'b0;
    v.eGnt   = g;
    v.eAck   = a;
    v.ePo    = p;
    v.eBusy  = b;
    v.eOwner = o;
    return v;
  endfunction

  task automatic modelStep();
    bit hit;
    int j;
    hit = 1'b0;
    case (mSlot)
      0: begin
        if (rClr) begin
          mPo = '0;
        end else if (rReq != '0) begin
          for (int k = 0; k < N; k++) begin
            j = (mPtr + k) % N;
            if (!hit && rReq[j]) begin
              hit    = 1'b1;
              mOwner = j;
            end
          end
          mSlot = 1;
        end
      end
      1: begin
        if (rReq[mOwner]) begin
          mPo   = rData[mOwner*W +: W];
          mPtr  = (mOwner + 1) % N;
          mSlot = 2;
        end else begin
          mSlot = 0;
        end
      end
      default: mSlot = 0;
    endcase
    mGnt = '0;
    mAck = '0;
    if (mSlot == 1) mGnt[mOwner] = 1'b1;
    if (mSlot == 2) mAck[mOwner] = 1'b1;
    mBusy = (mSlot != 0);
  endtask

  // Main test sequence.
  initial begin
    rst = 1'b0;
    applyStimulus('0, '0, 1'b0);
    repeat (2) tick();
    checkOutput("reset_values", 4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0);
    rst = 1'b1;

    // Single write from reset.
    applyStimulus(4'b0001, 32'h00000094, 1'b0);
    tick(); checkOutput("single_e1", 4'b0001, 4'b0000, 8'h00, 1'b1, 2'd0);
    tick(); checkOutput("single_e2", 4'b0000, 4'b0001, 8'h94, 1'b1, 2'd0);
    applyStimulus(4'b0000, 32'h00000094, 1'b0);
    tick(); checkOutput("single_e3", 4'b0000, 4'b0000, 8'h94, 1'b0, 2'd0);

    // Round-robin walk, wrap and pointer fairness from a fresh reset.
    resetPulse();
    vecs.push_back(mkVec(4'b1111, 4'b0001, 4'b0000, 8'h00, 1'b1, 2'd0));
    vecs.push_back(mkVec(4'b1111, 4'b0000, 4'b0001, 8'h10, 1'b1, 2'd0));
    vecs.push_back(mkVec(4'b1110, 4'b0000, 4'b0000, 8'h10, 1'b0, 2'd0));
    vecs.push_back(mkVec(4'b1110, 4'b0010, 4'b0000, 8'h10, 1'b1, 2'd1));
    vecs.push_back(mkVec(4'b1110, 4'b0000, 4'b0010, 8'h11, 1'b1, 2'd1));
    vecs.push_back(mkVec(4'b1100, 4'b0000, 4'b0000, 8'h11, 1'b0, 2'd1));
    vecs.push_back(mkVec(4'b1100, 4'b0100, 4'b0000, 8'h11, 1'b1, 2'd2));
    vecs.push_back(mkVec(4'b1100, 4'b0000, 4'b0100, 8'h12, 1'b1, 2'd2));
    vecs.push_back(mkVec(4'b1000, 4'b0000, 4'b0000, 8'h12, 1'b0, 2'd2));
    vecs.push_back(mkVec(4'b1001, 4'b1000, 4'b0000, 8'h12, 1'b1, 2'd3));
    vecs.push_back(mkVec(4'b1001, 4'b0000, 4'b1000, 8'h13, 1'b1, 2'd3));
    vecs.push_back(mkVec(4'b0001, 4'b0000, 4'b0000, 8'h13, 1'b0, 2'd3));
    vecs.push_back(mkVec(4'b0001, 4'b0001, 4'b0000, 8'h13, 1'b1, 2'd0));
    vecs.push_back(mkVec(4'b0001, 4'b0000, 4'b0001, 8'h10, 1'b1, 2'd0));
    vecs.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 8'h10, 1'b0, 2'd0));
    vecs.push_back(mkVec(4'b0100, 4'b0100, 4'b0000, 8'h10, 1'b1, 2'd2));
    vecs.push_back(mkVec(4'b0100, 4'b0000, 4'b0100, 8'h12, 1'b1, 2'd2));
    vecs.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 8'h12, 1'b0, 2'd2));
    vecs.push_back(mkVec(4'b0101, 4'b0001, 4'b0000, 8'h12, 1'b1, 2'd0));
    vecs.push_back(mkVec(4'b0101, 4'b0000, 4'b0001, 8'h10, 1'b1, 2'd0));
    vecs.push_back(mkVec(4'b0100, 4'b0000, 4'b0000, 8'h10, 1'b0, 2'd0));
    vecs.push_back(mkVec(4'b0100, 4'b0100, 4'b0000, 8'h10, 1'b1, 2'd2));
    vecs.push_back(mkVec(4'b0100, 4'b0000, 4'b0100, 8'h12, 1'b1, 2'd2));
    vecs.push_back(mkVec(4'b0000, 4'b0000, 4'b0000, 8'h12, 1'b0, 2'd2));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].data, vecs[i].clr);
      tick();
      checkOutput($sformatf("rr_row%0d", i), vecs[i].eGnt, vecs[i].eAck, vecs[i].ePo,
                  vecs[i].eBusy, vecs[i].eOwner);
    end

    // Abort: serve 0 to put ptr at 1, then abort 1 and show ptr stayed at 1.
    applyStimulus(4'b0001, 32'h77665544, 1'b0);
    tick(); checkOutput("ab_g0", 4'b0001, 4'b0000, 8'h12, 1'b1, 2'd0);
    tick(); checkOutput("ab_a0", 4'b0000, 4'b0001, 8'h44, 1'b1, 2'd0);
    applyStimulus(4'b0000, 32'h77665544, 1'b0);
    tick(); checkOutput("ab_i0", 4'b0000, 4'b0000, 8'h44, 1'b0, 2'd0);
    applyStimulus(4'b0010, 32'h77665544, 1'b0);
    tick(); checkOutput("ab_g1", 4'b0010, 4'b0000, 8'h44, 1'b1, 2'd1);
    applyStimulus(4'b0000, 32'h77665544, 1'b0);
    tick(); checkOutput("ab_drop", 4'b0000, 4'b0000, 8'h44, 1'b0, 2'd1);
    applyStimulus(4'b0011, 32'h77665544, 1'b0);
    tick(); checkOutput("ab_regrant", 4'b0010, 4'b0000, 8'h44, 1'b1, 2'd1);
    tick(); checkOutput("ab_load", 4'b0000, 4'b0010, 8'h55, 1'b1, 2'd1);
    applyStimulus(4'b0000, 32'h77665544, 1'b0);
    tick(); checkOutput("ab_idle", 4'b0000, 4'b0000, 8'h55, 1'b0, 2'd1);

    // Clear priority: load A5 via requester 3, then clr together with req[2].
    applyStimulus(4'b1000, 32'hA53C0000, 1'b0);
    tick(); checkOutput("clr_g3", 4'b1000, 4'b0000, 8'h55, 1'b1, 2'd3);
    tick(); checkOutput("clr_a3", 4'b0000, 4'b1000, 8'hA5, 1'b1, 2'd3);
    applyStimulus(4'b0000, 32'hA53C0000, 1'b0);
    tick(); checkOutput("clr_i3", 4'b0000, 4'b0000, 8'hA5, 1'b0, 2'd3);
    applyStimulus(4'b0100, 32'hA53C0000, 1'b1);
    tick(); checkOutput("clr_wins", 4'b0000, 4'b0000, 8'h00, 1'b0, 2'd3);
    applyStimulus(4'b0100, 32'hA53C0000, 1'b0);
    tick(); checkOutput("clr_defer_g2", 4'b0100, 4'b0000, 8'h00, 1'b1, 2'd2);
    tick(); checkOutput("clr_load2", 4'b0000, 4'b0100, 8'h3C, 1'b1, 2'd2);
    applyStimulus(4'b0000, 32'hA53C0000, 1'b0);
    tick(); checkOutput("clr_idle", 4'b0000, 4'b0000, 8'h3C, 1'b0, 2'd2);

    // Asynchronous reset while requester 3 holds a grant.
    applyStimulus(4'b1000, 32'hA53C0000, 1'b0);
    tick(); checkOutput("ar_g3", 4'b1000, 4'b0000, 8'h3C, 1'b1, 2'd3);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ar_immediate", 4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0);
    applyStimulus(4'b0000, 32'hA53C0000, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(4'b1001, 32'hA53C0000, 1'b0);
    tick(); checkOutput("ar_ptr0", 4'b0001, 4'b0000, 8'h00, 1'b1, 2'd0);
    tick(); checkOutput("ar_load0", 4'b0000, 4'b0001, 8'h00, 1'b1, 2'd0);
    applyStimulus(4'b0000, 32'hA53C0000, 1'b0);
    tick(); checkOutput("ar_idle", 4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0);

    // Randomized requesters against the reference model.
    resetPulse();
    mSlot  = 0;
    mOwner = 0;
    mPtr   = 0;
    mPo    = '0;
    mGnt   = '0;
    mAck   = '0;
    mBusy  = 1'b0;
    rReq   = '0;
    rData  = '0;
    rClr   = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (rReq[i] && mAck[i]) begin
          rReq[i] = 1'b0;
        end else if (rReq[i] && mGnt[i] && ($urandom % 8 == 0)) begin
          rReq[i] = 1'b0;
        end else if (!rReq[i] && ($urandom % 3 == 0)) begin
          rReq[i]         = 1'b1;
          rData[i*W +: W] = W'($urandom);
        end
      end
      rClr = ($urandom % 6 == 0);
      applyStimulus(rReq, rData, rClr);
      modelStep();
      tick();
      checkOutput($sformatf("rand%0d", cyc), mGnt, mAck, mPo, mBusy, 2'(mOwner));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
